// File: rtl/alu_seq_pkg.sv
// Shared widths, FSM encoding and command layout for the ALU command sequencer.
package alu_seq_pkg;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} seq_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer; ready is a registered not-full so a same-edge pop never admits a push into a full buffer.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_cmd_t wdata,
  input  logic     pop,
  output alu_cmd_t rdata,
  output logic     empty,
  output logic     ready
);
  localparam int AW = $clog2(FIFO_DEPTH);

  alu_cmd_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic            do_push, do_pop;

  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  // Pointers wrap for free because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      ready <= (count_nxt != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives an external combinational ALU one command at a time and holds each result
// until accepted. Define ALU_SEQ_OPCOUNT_EN to build the completed-response counter; otherwise op_count is 0.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic [15:0]       op_count
);
  seq_state_t state, state_nxt;
  alu_cmd_t   head;
  logic       fifo_empty;
  logic       pop, capture, rsp_done;

  alu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata ('{a: cmd_a, b: cmd_b, sel: cmd_sel}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .ready (cmd_ready)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = DRIVE;
      end
      DRIVE: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (rsp_ready) begin
        rsp_done = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // alu_* only change on a pop, so they keep the last command while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_sel    <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_sel <= head.sel;
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_out;
        rsp_carry  <= alu_carry;
        rsp_sel    <= alu_sel;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           op_count_q <= '0;
    else if (rsp_done) op_count_q <= op_count_q + 16'd1;
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif
endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command buffer entries, power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have cmd_valid, input, 1, and cmd_ready, output, 1: command handshake.
REQ-005 SHALL have cmd_a, input, 8, and cmd_b, input, 8: operands.
REQ-006 SHALL have cmd_sel, input, 4: ALU opcode.
REQ-007 SHALL have alu_a, output, 8; alu_b, output, 8; alu_sel, output, 4: registered drive to the combinational alu.
REQ-008 SHALL have alu_out, input, 8, and alu_carry, input, 1: alu result and CarryOut.
REQ-009 SHALL have rsp_valid, output, 1, and rsp_ready, input, 1: response handshake.
REQ-010 SHALL have rsp_result, output, 8; rsp_carry, output, 1; rsp_sel, output, 4: captured result and its echoed opcode.
REQ-011 SHALL have op_count, output, 16: completed-response counter.

Function
REQ-012 Command transfer SHALL occur on an edge where cmd_valid and cmd_ready are both 1; the command is then written to the FIFO.
REQ-013 cmd_ready SHALL equal not-full, registered only; a pop on the same edge SHALL NOT enable a push while full.
REQ-014 FIFO pointers SHALL wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 SHALL distinguish full from empty.
REQ-015 FSM states SHALL be IDLE, DRIVE, HOLD.
REQ-016 IDLE with FIFO non-empty: pop head, load alu_a/alu_b/alu_sel, go to DRIVE.
REQ-017 IDLE with FIFO empty: remain in IDLE; alu_* SHALL hold their last values.
REQ-018 DRIVE SHALL last exactly one cycle; on exit, capture alu_out into rsp_result, alu_carry into rsp_carry, alu_sel into rsp_sel; set rsp_valid=1; go to HOLD.
REQ-019 HOLD SHALL keep all rsp_* outputs stable while rsp_ready=0.
REQ-020 HOLD with rsp_ready=1: clear rsp_valid unless the next response is captured on the same edge; increment op_count; go to DRIVE with a pop if the FIFO is non-empty, else go to IDLE.
REQ-021 Latency SHALL be 2 cycles from command acceptance into an empty FIFO with the FSM in IDLE to rsp_valid=1; sustained throughput SHALL be one response per 2 cycles.
REQ-022 op_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-023 All 16 cmd_sel codes SHALL pass through unmodified; the block SHALL NOT decode opcodes.
REQ-024 Simultaneous push and pop with the FIFO not full SHALL leave occupancy unchanged.

Reset
REQ-025 On rst assertion, asynchronously: state=IDLE, FIFO empty, cmd_ready=0 during reset, alu_a=alu_b=0, alu_sel=0, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_sel=0, op_count=0.
REQ-026 Reset mid-operation SHALL discard buffered commands and any pending response without emitting it.
REQ-027 cmd_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-028 With macro ALU_SEQ_OPCOUNT_EN defined, op_count SHALL behave per REQ-020 and REQ-022.
REQ-029 Without ALU_SEQ_OPCOUNT_EN, op_count SHALL be constant 0 and no counter flops SHALL be synthesized.

Structure
REQ-030 Package alu_seq_pkg SHALL hold DATA_W=8, SEL_W=4, the FSM state enum, and the command struct {a, b, sel}.
REQ-031 The FIFO SHALL be a sub-module, alu_cmd_fifo, parameterised by FIFO_DEPTH.

Verification
REQ-032 Send cmd a=8'h05, b=8'h03, sel=4'b0000 (add) with rsp_ready=1 -> rsp_valid 2 cycles after acceptance; rsp_result=8'h08, rsp_carry=0, op_count=1.
REQ-033 Send add a=8'hFF, b=8'h01 -> rsp_result=8'h00, rsp_carry=1, rsp_sel=4'b0000.
REQ-034 Hold rsp_ready=0 and push 6 commands with FIFO_DEPTH=4 -> cmd_ready=0 after 5 acceptances (4 buffered plus 1 in HOLD); no command is lost; order is preserved after release.
REQ-035 With rsp_ready stuck at 1, send back-to-back commands -> one response every 2 cycles, rsp_sel matching issue order (e.g. 4'b1110 then 4'b0000).
REQ-036 Assert rst while in HOLD with 3 commands buffered -> all outputs reach reset values immediately; no response appears after release.
REQ-037 Preload op_count to 16'hFFFF via 65535 transactions, or force it, then complete one response -> op_count=16'h0000; the same build without ALU_SEQ_OPCOUNT_EN keeps op_count at 0 throughout.
